// File: rtl/axil_pkg.sv
`timescale 1ns/1ps
// Shared AXI4-lite definitions for the register-interface bridges.
// The read and write sides both import the response codes from here.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_reg_if_rd.sv
`timescale 1ns/1ps
// AXI4-lite read slave that turns each AR beat into a level-held register read
// request, with a wait-aware timeout that answers SLVERR if the target never acks.
module axil_reg_if_rd
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT);
  localparam int ALIGN_BITS = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    ~((ADDR_WIDTH'(1) << ALIGN_BITS) - ADDR_WIDTH'(1));

  state_t                state_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_WIDTH-1:0] rd_addr_d;
  logic                  arprot_unused;

  // Protection bits carry no meaning for a CSR target.
  assign arprot_unused = ^s_axil_arprot;
  assign rd_addr_d     = s_axil_araddr & ADDR_MASK;

  // Single-outstanding read FSM; every output is a flop so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arready_q && s_axil_arvalid) begin
            arready_q <= 1'b0;
            rd_addr_q <= rd_addr_d;
            rd_en_q   <= 1'b1;
            cnt_q     <= CNT_LOAD;
            state_q   <= ST_REQ;
          end else begin
            arready_q <= 1'b1;
          end
        end
        ST_REQ: begin
          // Ack has priority over both wait and an expired counter.
          if (reg_rd_ack) begin
            rdata_q  <= reg_rd_data;
            rresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b1;
            rd_en_q  <= 1'b0;
            state_q  <= ST_RESP;
          end else if (TIMEOUT_EN && (cnt_q == '0) && !reg_rd_wait) begin
            rdata_q  <= '0;
            rresp_q  <= RESP_SLVERR;
            rvalid_q <= 1'b1;
            rd_en_q  <= 1'b0;
            state_q  <= ST_RESP;
          end else if (TIMEOUT_EN && !reg_rd_wait) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            cnt_q <= cnt_q;
          end
        end
        ST_RESP: begin
          if (s_axil_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            rvalid_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          arready_q <= 1'b0;
          rvalid_q  <= 1'b0;
          rd_en_q   <= 1'b0;
        end
      endcase
    end
  end

  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign reg_rd_en      = rd_en_q;
  assign reg_rd_addr    = rd_addr_q;

endmodule
